load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: width of address and data paths.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 lsu_en_i  input  1  load/store instruction in execute; held high by the controller until lsu_done_o.
REQ-005 we_i  input  1  1 = store, 0 = load.
REQ-006 size_i  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-007 sign_ext_i  input  1  load result sign-extended when 1, zero-extended when 0.
REQ-008 addr_i  input  ADDR_WIDTH  effective byte address.
REQ-009 wdata_i  input  32  store data, right-aligned.
REQ-010 lsu_err_o  output  1  misalignment or illegal size; combinational, feeds the controller.
REQ-011 lsu_done_o  output  1  one-cycle pulse; transaction complete.
REQ-012 lsu_bus_err_o  output  1  pulses with lsu_done_o when the bus returned an error.
REQ-013 rdata_o  output  32  extended load result, valid while lsu_done_o is high.
REQ-014 data_req_o / data_gnt_i  output / input  1 / 1  bus request and grant.
REQ-015 data_addr_o  output  ADDR_WIDTH  word-aligned address; bits [1:0] always 00.
REQ-016 data_we_o, data_be_o[3:0], data_wdata_o[31:0]  output  bus write enable, byte enables, write data.
REQ-017 data_rvalid_i, data_err_i, data_rdata_i[31:0]  input  bus response valid, error and read data.

Function
REQ-018 lsu_err_o = lsu_en_i & state IDLE & (size 11 | half with addr[0]=1 | word with addr[1:0]!=00).
REQ-019 A transaction with lsu_err_o high SHALL issue no bus request and SHALL leave the state in IDLE.
REQ-020 FSM states: IDLE, REQ, WAIT_RESP; at most one transaction outstanding.
REQ-021 IDLE: lsu_en_i & ~lsu_err_o drives data_req_o combinationally in the same cycle.
REQ-022 IDLE: data_gnt_i high moves the FSM to WAIT_RESP; otherwise it moves to REQ.
REQ-023 In IDLE the FSM latches we, size, sign_ext, addr[1:0], word address, byte enables and write data.
REQ-024 REQ: data_req_o is held high with the latched attributes until data_gnt_i, then the FSM moves to WAIT_RESP.
REQ-025 REQ: the request is never retracted, even if lsu_en_i falls.
REQ-026 WAIT_RESP: data_req_o is 0; data_rvalid_i moves the FSM to IDLE and pulses lsu_done_o in the same cycle (zero-latency response path).
REQ-027 data_rvalid_i is ignored in IDLE and REQ.
REQ-028 lsu_en_i low when the response arrives: lsu_done_o is suppressed; the response is still consumed and the FSM still returns to IDLE.
REQ-029 A new transaction is accepted in IDLE no earlier than the cycle after lsu_done_o.
REQ-030 Byte enables: byte -> 0001<<addr[1:0]; half -> 0011 (addr[1]=0) or 1100 (addr[1]=1); word -> 1111.
REQ-031 Write data: byte replicated x4; half replicated x2; word unchanged.
REQ-032 data_we_o = latched we; data_wdata_o and data_be_o are also driven for loads, and the bus ignores them.
REQ-033 Loads: rdata_o selects the byte/half at the latched offset from data_rdata_i and extends it per sign_ext.
REQ-034 Stores: rdata_o = 0.
REQ-035 data_err_i with data_rvalid_i: lsu_bus_err_o = 1 and rdata_o = 0; lsu_done_o still pulses.
REQ-036 Outside a done cycle: lsu_done_o = 0, lsu_bus_err_o = 0, rdata_o = 0.

Reset
REQ-037 rst_n low: FSM -> IDLE; all latched fields cleared.
REQ-038 rst_n low: data_req_o = 0, lsu_done_o = 0, lsu_bus_err_o = 0; an in-flight transaction is abandoned without a completion pulse.
REQ-039 A response arriving after reset release while in IDLE is ignored.

Verification
REQ-040 Load byte, addr 0x1003, sign_ext=1, gnt same cycle, rvalid next cycle with rdata 0x80FF_FF12 -> data_addr 0x1000, be 1000, done pulse with rdata_o 0xFFFF_FF80.
REQ-041 Store half, addr 0x2002, wdata 0x1234ABCD, gnt delayed 3 cycles -> req held 4 cycles with stable attributes; be 1100, data_wdata 0xABCD_ABCD, done on rvalid.
REQ-042 Load word, addr 0x3001 -> lsu_err_o=1 same cycle, no data_req_o, FSM remains IDLE.
REQ-043 Load word, rvalid with data_err_i=1 -> done=1, bus_err=1, rdata_o=0; the next load starts in the following cycle.
REQ-044 rst_n asserted in WAIT_RESP, then a late rvalid after release -> no done pulse; the next transaction completes normally.
REQ-045 Load half unsigned, addr 0x4002, rdata 0x8001_0000 -> rdata_o 0x0000_8001.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Controller and data-bus signals of the load/store unit, grouped for port use.
// master = the LSU side, slave = controller plus memory bus (the bench).
interface load_store_unit_if #(parameter int ADDR_WIDTH = 32);
  logic                  lsu_en_i;
  logic                  we_i;
  logic [1:0]            size_i;
  logic                  sign_ext_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [31:0]           wdata_i;
  logic                  lsu_err_o;
  logic                  lsu_done_o;
  logic                  lsu_bus_err_o;
  logic [31:0]           rdata_o;
  logic                  data_req_o;
  logic                  data_gnt_i;
  logic [ADDR_WIDTH-1:0] data_addr_o;
  logic                  data_we_o;
  logic [3:0]            data_be_o;
  logic [31:0]           data_wdata_o;
  logic                  data_rvalid_i;
  logic                  data_err_i;
  logic [31:0]           data_rdata_i;

  modport master (
    input  lsu_en_i, we_i, size_i, sign_ext_i, addr_i, wdata_i,
    output lsu_err_o, lsu_done_o, lsu_bus_err_o, rdata_o,
    output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i
  );
  modport slave (
    output lsu_en_i, we_i, size_i, sign_ext_i, addr_i, wdata_i,
    input  lsu_err_o, lsu_done_o, lsu_bus_err_o, rdata_o,
    input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: aligns stores onto a 32-bit bus and
// extracts/extends loads, with a zero-latency response path back to the core.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  load_store_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP} state_t;

  state_t                state;
  logic                  we_q, sext_q;
  logic [1:0]            size_q, off_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [3:0]            be_q;
  logic [31:0]           wdata_q;

  logic                  idle, bad, start, resp, done;
  logic [3:0]            be_c;
  logic [31:0]           wdata_c, shifted, ld;
  logic [ADDR_WIDTH-1:0] waddr_c;

  assign idle    = (state == IDLE);
  assign waddr_c = {bus.addr_i[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    bad     = 1'b0;
    be_c    = 4'b1111;
    wdata_c = bus.wdata_i;
    unique case (bus.size_i)
      2'b00: begin
        be_c    = 4'b0001 << bus.addr_i[1:0];
        wdata_c = {4{bus.wdata_i[7:0]}};
      end
      2'b01: begin
        bad     = bus.addr_i[0];
        be_c    = bus.addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{bus.wdata_i[15:0]}};
      end
      2'b10:   bad = |bus.addr_i[1:0];
      default: bad = 1'b1;
    endcase
  end

  // The IDLE request is combinational, so keep it quiet while reset is held.
  assign start          = idle & bus.lsu_en_i & ~bad & rst_n;
  assign bus.lsu_err_o  = idle & bus.lsu_en_i & bad;
  assign bus.data_req_o = start | (state == REQ);
  assign bus.data_addr_o  = idle ? waddr_c    : waddr_q;
  assign bus.data_we_o    = idle ? bus.we_i   : we_q;
  assign bus.data_be_o    = idle ? be_c       : be_q;
  assign bus.data_wdata_o = idle ? wdata_c    : wdata_q;

  assign resp    = (state == WAIT_RESP) & bus.data_rvalid_i;
  assign done    = resp & bus.lsu_en_i;
  assign shifted = bus.data_rdata_i >> {off_q, 3'b000};

  always_comb begin
    ld = bus.data_rdata_i;
    unique case (size_q)
      2'b00:   ld = {{24{sext_q & shifted[7]}},  shifted[7:0]};
      2'b01:   ld = {{16{sext_q & shifted[15]}}, shifted[15:0]};
      default: ld = bus.data_rdata_i;
    endcase
  end

  assign bus.lsu_done_o    = done;
  assign bus.lsu_bus_err_o = done & bus.data_err_i;
  assign bus.rdata_o       = (done & ~bus.data_err_i & ~we_q) ? ld : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      size_q  <= 2'b00;
      off_q   <= 2'b00;
      waddr_q <= '0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          we_q    <= bus.we_i;
          sext_q  <= bus.sign_ext_i;
          size_q  <= bus.size_i;
          off_q   <= bus.addr_i[1:0];
          waddr_q <= waddr_c;
          be_q    <= be_c;
          wdata_q <= wdata_c;
          state   <= bus.data_gnt_i ? WAIT_RESP : REQ;
        end
        REQ:       if (bus.data_gnt_i)    state <= WAIT_RESP;
        WAIT_RESP: if (bus.data_rvalid_i) state <= IDLE;
        default:                          state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: stimulus pushes expected completions, a negedge monitor pops
// and compares them whenever the unit signals done.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  logic [32:0] exp_q[$];   // {bus_err, rdata}

  load_store_unit_if #(.ADDR_WIDTH(32)) lif();
  load_store_unit #(.ADDR_WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(lif));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear();
    lif.lsu_en_i = 0; lif.we_i = 0; lif.size_i = 0; lif.sign_ext_i = 0;
    lif.addr_i = 0; lif.wdata_i = 0; lif.data_gnt_i = 0;
    lif.data_rvalid_i = 0; lif.data_err_i = 0; lif.data_rdata_i = 0;
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic sext,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic gnt);
    lif.lsu_en_i = 1; lif.we_i = we; lif.size_i = size; lif.sign_ext_i = sext;
    lif.addr_i = addr; lif.wdata_i = wdata; lif.data_gnt_i = gnt;
  endtask

  task automatic respond(input logic err, input logic [31:0] rdata);
    lif.data_gnt_i = 0; lif.data_rvalid_i = 1; lif.data_err_i = err; lif.data_rdata_i = rdata;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (lif.lsu_done_o) begin
      if (exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_done: got done=1 rdata=%h expected no completion", lif.rdata_o);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("done_bus_err", {31'b0, lif.lsu_bus_err_o}, {31'b0, e[32]});
        chk("done_rdata", lif.rdata_o, e[31:0]);
      end
    end else if (lif.lsu_bus_err_o || lif.rdata_o != 0) begin
      vectors++; miscompares++;
      $display("FAIL idle_outputs: got bus_err=%b rdata=%h expected 0/0", lif.lsu_bus_err_o, lif.rdata_o);
    end
  end

  initial begin
    clear();
    rst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_req", {31'b0, lif.data_req_o}, 0);
    chk("rst_done", {31'b0, lif.lsu_done_o}, 0);
    chk("rst_bus_err", {31'b0, lif.lsu_bus_err_o}, 0);
    step(); rst_n = 1;

    // Signed byte load at offset 3, granted immediately
    issue(0, 2'b00, 1, 32'h1003, 32'h0, 1);
    exp_q.push_back({1'b0, 32'hFFFF_FF80});
    @(negedge clk);
    chk("t1_req", {31'b0, lif.data_req_o}, 1);
    chk("t1_addr", lif.data_addr_o, 32'h1000);
    chk("t1_be", {28'b0, lif.data_be_o}, 32'h8);
    chk("t1_err", {31'b0, lif.lsu_err_o}, 0);
    step(); respond(0, 32'h80FF_FF12);
    @(negedge clk);
    chk("t1_wait_req", {31'b0, lif.data_req_o}, 0);
    step(); clear();

    // Half store with grant delayed 3 cycles; inputs scrambled after acceptance
    issue(1, 2'b01, 0, 32'h2002, 32'h1234_ABCD, 0);
    for (int c = 0; c < 4; c++) begin
      if (c == 3) lif.data_gnt_i = 1;
      @(negedge clk);
      chk("t2_req", {31'b0, lif.data_req_o}, 1);
      chk("t2_addr", lif.data_addr_o, 32'h2000);
      chk("t2_be", {28'b0, lif.data_be_o}, 32'hC);
      chk("t2_wdata", lif.data_wdata_o, 32'hABCD_ABCD);
      chk("t2_we", {31'b0, lif.data_we_o}, 1);
      step();
      if (c == 0) begin lif.addr_i = 32'h7777; lif.wdata_i = 0; lif.size_i = 2'b00; lif.we_i = 0; end
    end
    exp_q.push_back({1'b0, 32'h0});
    respond(0, 32'hFFFF_FFFF);
    @(negedge clk);
    step(); clear();

    // Misaligned word load: error, no request, stays idle even with stray rvalid
    issue(0, 2'b10, 0, 32'h3001, 32'h0, 1);
    @(negedge clk);
    chk("t3_err", {31'b0, lif.lsu_err_o}, 1);
    chk("t3_req", {31'b0, lif.data_req_o}, 0);
    step(); lif.data_rvalid_i = 1; lif.data_rdata_i = 32'h1234_5678;
    @(negedge clk);
    chk("t3_err2", {31'b0, lif.lsu_err_o}, 1);
    chk("t3_req2", {31'b0, lif.data_req_o}, 0);
    step(); clear();
    @(negedge clk);
    chk("t3_err_off", {31'b0, lif.lsu_err_o}, 0);
    step();

    // Word load with bus error, followed back-to-back by unsigned half load
    issue(0, 2'b10, 0, 32'h3004, 32'h0, 1);
    exp_q.push_back({1'b1, 32'h0});
    @(negedge clk);
    chk("t4_req", {31'b0, lif.data_req_o}, 1);
    chk("t4_be", {28'b0, lif.data_be_o}, 32'hF);
    step(); respond(1, 32'hDEAD_BEEF);
    @(negedge clk);
    step(); clear();
    issue(0, 2'b01, 0, 32'h4002, 32'h0, 1);
    exp_q.push_back({1'b0, 32'h0000_8001});
    @(negedge clk);
    chk("t5_req", {31'b0, lif.data_req_o}, 1);
    chk("t5_addr", lif.data_addr_o, 32'h4000);
    chk("t5_be", {28'b0, lif.data_be_o}, 32'hC);
    step(); respond(0, 32'h8001_0000);
    @(negedge clk);
    step(); clear();

    // Byte store whose response arrives after lsu_en_i drops: no done
    issue(1, 2'b00, 0, 32'h6001, 32'h0000_005A, 1);
    @(negedge clk);
    chk("t6_be", {28'b0, lif.data_be_o}, 32'h2);
    chk("t6_wdata", lif.data_wdata_o, 32'h5A5A_5A5A);
    chk("t6_addr", lif.data_addr_o, 32'h6000);
    step(); respond(0, 32'h0); lif.lsu_en_i = 0;
    @(negedge clk);
    step(); clear();
    issue(0, 2'b01, 1, 32'h6000, 32'h0, 1);
    exp_q.push_back({1'b0, 32'hFFFF_F00D});
    @(negedge clk);
    chk("t6_next_req", {31'b0, lif.data_req_o}, 1);
    step(); respond(0, 32'h0000_F00D);
    @(negedge clk);
    step(); clear();

    // Reset while waiting for a response, late rvalid ignored afterwards
    issue(0, 2'b00, 0, 32'h5000, 32'h0, 1);
    @(negedge clk);
    step(); lif.data_gnt_i = 0; rst_n = 0;
    @(negedge clk);
    chk("t7_rst_req", {31'b0, lif.data_req_o}, 0);
    chk("t7_rst_done", {31'b0, lif.lsu_done_o}, 0);
    step(); rst_n = 1;
    issue(0, 2'b00, 0, 32'h5001, 32'h0, 0);
    lif.data_rvalid_i = 1; lif.data_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("t7_idle_req", {31'b0, lif.data_req_o}, 1);
    step(); lif.data_gnt_i = 1;
    @(negedge clk);
    chk("t7_req_hold", {31'b0, lif.data_req_o}, 1);
    chk("t7_req_addr", lif.data_addr_o, 32'h5000);
    step();
    exp_q.push_back({1'b0, 32'h0000_00A5});
    respond(0, 32'h0000_A500);
    @(negedge clk);
    step(); clear();

    repeat (2) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
